// File: rtl/nios_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug scan master.
// Holds the FSM state enum, default widths and the per-command step count.
package nios_debug_scan_pkg;

    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    // UIR + RTI + CDR + DR_WIDTH shift steps + UDR
    localparam int STEP_COUNT = DR_WIDTH_DEF + 4;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        RTI,
        CDR,
        SHIFT,
        UDR,
        RESP
    } state_t;

    function automatic int scan_latency(input int dr_width, input int tck_half);
        return (dr_width + 4) * 2 * tck_half + 1;
    endfunction

endpackage

// File: rtl/nios_debug_scan_tck_gen.sv
// Test-clock generator: one step is 2*TCK_HALF clk cycles, tck low then high.
// Ports: clk, reset, run (enable); tck, step_start (last cycle of a step), tck_rise.
module nios_debug_scan_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic step_start,
    output logic tck_rise
);

    localparam int CW = $clog2(2 * TCK_HALF);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_HALF - 1);
    localparam logic [CW-1:0] RISE = CW'(TCK_HALF);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // Counter and tck sit at zero whenever no scan is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (run) begin
            cnt <= cnt_next;
            tck <= (cnt_next >= RISE);
        end else begin
            cnt <= '0;
            tck <= 1'b0;
        end
    end

    // tck_rise marks the first high cycle; step_start marks the cycle whose
    // closing clk edge begins the next step.
    assign tck_rise   = run && (cnt == RISE);
    assign step_start = run && (cnt == LAST);

endmodule

// File: rtl/nios_debug_scan_master.sv
// Virtual-JTAG initiator for the Nios II debug slave: one IR load plus one
// full DR scan per command. Ports: cmd_* in, rsp_* out, vji_* to/from slave.
module nios_debug_scan_master
    import nios_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_rti,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

    state_t              state;
    logic [DR_WIDTH-1:0] sh;
    logic [DR_WIDTH-1:0] capture;
    logic [BW-1:0]       bit_cnt;
    logic                run;
    logic                step_end;
    logic                tck_rise;

    assign run       = (state != IDLE) && (state != RESP);
    assign cmd_ready = (state == IDLE) && !rsp_valid;

    nios_debug_scan_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .tck       (vji_tck),
        .step_start(step_end),
        .tck_rise  (tck_rise)
    );

    // All step outputs change on the edge that closes the previous step,
    // so they are stable for the whole following step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            capture    <= '0;
            bit_cnt    <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_rti    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        sh        <= cmd_data;
                        capture   <= '0;
                        bit_cnt   <= '0;
                        vji_tdi   <= 1'b0;
                        vji_ir_in <= cmd_ir;
                        vji_uir   <= 1'b1;
                        state     <= UIR;
                    end
                end
                UIR: begin
                    if (tck_rise) rsp_ir_out <= vji_ir_out;
                    if (step_end) begin
                        vji_uir <= 1'b0;
                        vji_rti <= 1'b1;
                        state   <= RTI;
                    end
                end
                RTI: begin
                    if (step_end) begin
                        vji_rti <= 1'b0;
                        vji_cdr <= 1'b1;
                        state   <= CDR;
                    end
                end
                CDR: begin
                    if (step_end) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= sh[0];
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tck_rise) capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
                    if (step_end) begin
                        sh <= sh >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            vji_sdr <= 1'b0;
                            vji_udr <= 1'b1;
                            vji_tdi <= 1'b0;
                            state   <= UDR;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            vji_tdi <= sh[1];
                        end
                    end
                end
                UDR: begin
                    if (step_end) begin
                        vji_udr   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= capture;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Directed bench for nios_debug_scan_master: default build plus a TCK_HALF=1
// build, each looped back through a 38-bit slave shift-register model.
module tb_nios_debug_scan_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT 0 (TCK_HALF=2) ----------------
    logic        cmd_valid0 = 1'b0;
    logic        rsp_ready0 = 1'b1;
    logic [1:0]  cmd_ir0 = '0;
    logic [37:0] cmd_data0 = '0;
    logic [1:0]  ir_out0 = '0;
    logic        cmd_ready0, rsp_valid0, vji_tck0, vji_tdi0, vji_tdo0;
    logic [37:0] rsp_data0;
    logic [1:0]  rsp_ir_out0, vji_ir_in0;
    logic        vji_uir0, vji_rti0, vji_cdr0, vji_sdr0, vji_udr0;

    nios_debug_scan_master dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_ir(cmd_ir0), .cmd_data(cmd_data0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_data(rsp_data0), .rsp_ir_out(rsp_ir_out0),
        .vji_tck(vji_tck0), .vji_tdi(vji_tdi0), .vji_tdo(vji_tdo0),
        .vji_ir_in(vji_ir_in0), .vji_ir_out(ir_out0),
        .vji_uir(vji_uir0), .vji_rti(vji_rti0), .vji_cdr(vji_cdr0),
        .vji_sdr(vji_sdr0), .vji_udr(vji_udr0)
    );

    // ---------------- DUT 1 (TCK_HALF=1) ----------------
    logic        cmd_valid1 = 1'b0;
    logic        rsp_ready1 = 1'b1;
    logic [1:0]  cmd_ir1 = '0;
    logic [37:0] cmd_data1 = '0;
    logic [1:0]  ir_out1 = '0;
    logic        cmd_ready1, rsp_valid1, vji_tck1, vji_tdi1, vji_tdo1;
    logic [37:0] rsp_data1;
    logic [1:0]  rsp_ir_out1, vji_ir_in1;
    logic        vji_uir1, vji_rti1, vji_cdr1, vji_sdr1, vji_udr1;

    nios_debug_scan_master #(.TCK_HALF(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1),
        .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
        .vji_ir_in(vji_ir_in1), .vji_ir_out(ir_out1),
        .vji_uir(vji_uir1), .vji_rti(vji_rti1), .vji_cdr(vji_cdr1),
        .vji_sdr(vji_sdr1), .vji_udr(vji_udr1)
    );

    wire [4:0]  code0 = {vji_udr0, vji_sdr0, vji_cdr0, vji_rti0, vji_uir0};
    wire [4:0]  code1 = {vji_udr1, vji_sdr1, vji_cdr1, vji_rti1, vji_uir1};
    wire [49:0] outs0 = {vji_tck0, vji_tdi0, vji_ir_in0, code0,
                         rsp_valid0, rsp_data0, rsp_ir_out0};
    wire [49:0] outs1 = {vji_tck1, vji_tdi1, vji_ir_in1, code1,
                         rsp_valid1, rsp_data1, rsp_ir_out1};

    // ---------------- slave shift-register models ----------------
    logic        load0 = 1'b0, load1 = 1'b0;
    logic [37:0] load_val0 = '0, load_val1 = '0;
    logic [37:0] model0 = '0, model1 = '0;
    logic        tck_q0 = 1'b0, tck_q1 = 1'b0;
    int          rises0 = 0, rises1 = 0, sdr_n0 = 0, sdr_n1 = 0;
    int          overlap0 = 0, overlap1 = 0;
    logic [4:0]  seq0[$];
    logic [4:0]  seq1[$];

    assign vji_tdo0 = model0[0];
    assign vji_tdo1 = model1[0];

    // The model shifts on the clk edge that ends the tck-high-rise cycle,
    // which is the same edge the master samples tdo on.
    always @(posedge clk) begin
        tck_q0 <= vji_tck0;
        if (load0) model0 <= load_val0;
        else if (vji_tck0 && !tck_q0) begin
            rises0 <= rises0 + 1;
            seq0.push_back(code0);
            if (vji_sdr0) begin
                model0 <= {vji_tdi0, model0[37:1]};
                sdr_n0 <= sdr_n0 + 1;
            end
        end
        if ($countones(code0) > 1) overlap0 <= overlap0 + 1;
    end

    always @(posedge clk) begin
        tck_q1 <= vji_tck1;
        if (load1) model1 <= load_val1;
        else if (vji_tck1 && !tck_q1) begin
            rises1 <= rises1 + 1;
            seq1.push_back(code1);
            if (vji_sdr1) begin
                model1 <= {vji_tdi1, model1[37:1]};
                sdr_n1 <= sdr_n1 + 1;
            end
        end
        if ($countones(code1) > 1) overlap1 <= overlap1 + 1;
    end

    // ---------------- helpers ----------------
    task automatic load_model(input bit d, input logic [37:0] v);
        @(negedge clk);
        if (d) begin load1 = 1'b1; load_val1 = v; end
        else   begin load0 = 1'b1; load_val0 = v; end
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic issue(input bit d, input logic [1:0] ir, input logic [37:0] data);
        int w;
        @(negedge clk);
        if (d) begin cmd_valid1 = 1'b1; cmd_ir1 = ir; cmd_data1 = data; end
        else   begin cmd_valid0 = 1'b1; cmd_ir0 = ir; cmd_data0 = data; end
        w = 0;
        while (!(d ? cmd_ready1 : cmd_ready0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", d ? cmd_ready1 : cmd_ready0, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
    endtask

    // lat counts negedges from the first cycle after accept (cycle T0+1 -> 1).
    task automatic wait_rsp(input bit d, output int lat, output logic [37:0] data,
                            output logic [1:0] iro, output logic [2:0] first);
        lat = 0;
        first = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) first = d ? {vji_uir1, vji_ir_in1} : {vji_uir0, vji_ir_in0};
        end while (!(d ? rsp_valid1 : rsp_valid0) && lat < 400);
        data = d ? rsp_data1 : rsp_data0;
        iro  = d ? rsp_ir_out1 : rsp_ir_out0;
    endtask

    function automatic int seq_errs(input logic [4:0] q[$], input int st);
        int e;
        logic [4:0] exp;
        e = 0;
        for (int i = 0; i < 42 && st + i < q.size(); i++) begin
            exp = (i == 0)  ? 5'b00001 :
                  (i == 1)  ? 5'b00010 :
                  (i == 2)  ? 5'b00100 :
                  (i == 41) ? 5'b10000 : 5'b01000;
            if (q[st + i] !== exp) e++;
        end
        return e;
    endfunction

    // ---------------- stimulus ----------------
    int          lat, st, s0, r0, w, bad, bad_data, bad_code;
    logic [37:0] data;
    logic [1:0]  iro;
    logic [2:0]  first;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs0", outs0, 50'd0);
        check("reset_outs1", outs1, 50'd0);
        check("reset_ready0", cmd_ready0, 1'b1);
        reset = 1'b0;

        // Loopback scan on the default build.
        ir_out0 = 2'b01;
        load_model(0, 38'h00_1234_5678);
        st = seq0.size();
        s0 = sdr_n0;
        issue(0, 2'b01, 38'h2A_DEAD_BEEF);
        wait_rsp(0, lat, data, iro, first);
        check("t1_latency", lat, 169);
        check("t1_rsp_data", data, 38'h00_1234_5678);
        check("t1_first_uir", first, 3'b101);
        check("t1_ir_out", iro, 2'b01);
        @(negedge clk);
        check("t1_model", model0, 38'h2A_DEAD_BEEF);
        check("t1_sdr_edges", sdr_n0 - s0, 38);
        check("t1_seq_len", seq0.size() - st, 42);
        check("t1_seq", seq_errs(seq0, st), 0);

        // IR path: ir_out capture and ir_in hold.
        ir_out0 = 2'b10;
        load_model(0, 38'h3);
        issue(0, 2'b11, 38'h1);
        wait_rsp(0, lat, data, iro, first);
        check("t2_ir_out", iro, 2'b10);
        check("t2_first_uir", first, 3'b111);
        check("t2_rsp_data", data, 38'h3);
        repeat (4) @(negedge clk);
        check("t2_idle_ready", cmd_ready0, 1'b1);
        check("t2_idle_ir_in", vji_ir_in0, 2'b11);
        check("t2_idle_code_tck", {vji_tck0, code0}, 6'd0);

        // Response back-pressure.
        rsp_ready0 = 1'b0;
        load_model(0, 38'h2B_C0DE_1234);
        issue(0, 2'b00, 38'h11_1111_1111);
        wait_rsp(0, lat, data, iro, first);
        check("t3_latency", lat, 169);
        check("t3_rsp_data", data, 38'h2B_C0DE_1234);
        cmd_valid0 = 1'b1;
        cmd_ir0    = 2'b01;
        cmd_data0  = 38'h05_A5A5_0F0F;
        r0 = rises0;
        bad = 0;
        bad_data = 0;
        bad_code = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready0 !== 1'b0) bad++;
            if (rsp_data0 !== 38'h2B_C0DE_1234 || rsp_valid0 !== 1'b1) bad_data++;
            if (code0 !== 5'd0 || vji_tck0 !== 1'b0) bad_code++;
            if (i == 10) begin
                load0 = 1'b1;
                load_val0 = 38'h1E_0000_0001;
            end else begin
                load0 = 1'b0;
            end
        end
        check("t3_ready_low", bad, 0);
        check("t3_rsp_stable", bad_data, 0);
        check("t3_quiet_outs", bad_code, 0);
        check("t3_no_tck", rises0 - r0, 0);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        check("t3_ready_after", cmd_ready0, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b0;
        wait_rsp(0, lat, data, iro, first);
        check("t3_next_latency", lat, 169);
        check("t3_next_data", data, 38'h1E_0000_0001);

        // Asynchronous reset in the middle of the shift.
        load_model(0, 38'h0F_F00F_F00F);
        s0 = sdr_n0;
        issue(0, 2'b10, 38'h33_3333_3333);
        w = 0;
        while (sdr_n0 - s0 < 17 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("t4_reach_bit17", sdr_n0 - s0, 17);
        #2 reset = 1'b1;
        #1;
        check("t4_async_outs", outs0, 50'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        r0 = rises0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid0 !== 1'b0) bad++;
        end
        check("t4_no_rsp", bad, 0);
        check("t4_no_tck", rises0 - r0, 0);
        load_model(0, 38'h15_5555_AAAA);
        st = seq0.size();
        issue(0, 2'b01, 38'h0A_0F0F_F0F0);
        wait_rsp(0, lat, data, iro, first);
        check("t4_latency", lat, 169);
        check("t4_rsp_data", data, 38'h15_5555_AAAA);
        @(negedge clk);
        check("t4_model", model0, 38'h0A_0F0F_F0F0);
        check("t4_seq", seq_errs(seq0, st), 0);

        // TCK_HALF=1 build, back-to-back commands.
        load_model(1, 38'h0);
        issue(1, 2'b00, 38'h3F_FFFF_FFFF);
        wait_rsp(1, lat, data, iro, first);
        check("t5a_latency", lat, 85);
        check("t5a_rsp_data", data, 38'h0);
        st = seq1.size();
        issue(1, 2'b00, 38'h0);
        wait_rsp(1, lat, data, iro, first);
        check("t5b_latency", lat, 85);
        check("t5b_rsp_data", data, 38'h3F_FFFF_FFFF);
        @(negedge clk);
        check("t5b_model", model1, 38'h0);
        check("t5b_seq_len", seq1.size() - st, 42);
        check("t5b_seq", seq_errs(seq1, st), 0);

        check("overlap0", overlap0, 0);
        check("overlap1", overlap1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
